exu_seq_ctrl: RTL

//  Multi-cycle sequencer for the RV64 EXU/register-file datapath. Fetches one instruction per

---
 rtl/exu_seq_ctrl_if.sv | 43 ++++
 rtl/exu_seq_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/exu_seq_ctrl_if.sv
// Bundle of the sequencer's IFU/EXU/LSU/status signals.
//   master : the sequencer (drives ifu_req, ir, pc, rf_wen, lsu_req, lsu_we, halt, err)
//   slave  : the surrounding datapath / sim top (drives ifu_valid, ifu_inst, dnpc, lsu_done)
// Optional performance counters (cycle_cnt, instret_cnt) exist only when
// EXU_SEQ_PERF_CNT_EN is defined.
interface exu_seq_ctrl_if #(
    parameter int unsigned XLEN = 64
);
    logic            ifu_req;
    logic            ifu_valid;
    logic [31:0]     ifu_inst;
    logic [31:0]     ir;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] dnpc;
    logic            rf_wen;
    logic            lsu_req;
    logic            lsu_we;
    logic            lsu_done;
    logic            halt;
    logic            err;
`ifdef EXU_SEQ_PERF_CNT_EN
    logic [63:0]     cycle_cnt;
    logic [63:0]     instret_cnt;

    modport master (
        output ifu_req, ir, pc, rf_wen, lsu_req, lsu_we, halt, err, cycle_cnt, instret_cnt,
        input  ifu_valid, ifu_inst, dnpc, lsu_done
    );
    modport slave (
        input  ifu_req, ir, pc, rf_wen, lsu_req, lsu_we, halt, err, cycle_cnt, instret_cnt,
        output ifu_valid, ifu_inst, dnpc, lsu_done
    );
`else
    modport master (
        output ifu_req, ir, pc, rf_wen, lsu_req, lsu_we, halt, err,
        input  ifu_valid, ifu_inst, dnpc, lsu_done
    );
    modport slave (
        input  ifu_req, ir, pc, rf_wen, lsu_req, lsu_we, halt, err,
        output ifu_valid, ifu_inst, dnpc, lsu_done
    );
`endif
endinterface

// File: rtl/exu_seq_ctrl.sv
// Multi-cycle sequencer for the RV64 EXU/register-file datapath.
// Fetches one instruction per iteration, steps through EXEC / MEM / WB, owns the PC and the
// GPR write enable, and halts on ebreak (err=0) or on an LSU timeout (err=1).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : exu_seq_ctrl_if.master (IFU handshake, ir/pc/dnpc, rf_wen, LSU handshake, halt/err)
// All outputs are registers; there is no input-to-output combinational path.
// Define EXU_SEQ_PERF_CNT_EN to add cycle_cnt / instret_cnt performance counters.
module exu_seq_ctrl #(
    parameter int unsigned     XLEN        = 64,
    parameter logic [XLEN-1:0] RESET_PC    = 64'h8000_0000,
    parameter int unsigned     TO_W        = 8,
    parameter logic [TO_W-1:0] MEM_TIMEOUT = 8'd255
) (
    input logic            clk,
    input logic            rst_n,
    exu_seq_ctrl_if.master bus
);

    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [31:0] EBREAK     = 32'h0010_0073;

    typedef enum logic [2:0] {StIdle, StFetch, StExec, StMem, StWb, StHalt} state_e;

    state_e          state_q;
    logic [TO_W-1:0] to_cnt_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     ir_q;
    logic            ifu_req_q;
    logic            rf_wen_q;
    logic            lsu_req_q;
    logic            lsu_we_q;
    logic            halt_q;
    logic            err_q;

    logic is_load;
    logic is_store;
    logic is_ebreak;
    logic wb_wen;

    assign is_load   = (ir_q[6:0] == OPC_LOAD);
    assign is_store  = (ir_q[6:0] == OPC_STORE);
    assign is_ebreak = (ir_q == EBREAK);
    // rd==x0 never writes; store/branch encode immediate bits in [11:7], not rd
    assign wb_wen    = (ir_q[11:7] != 5'd0) && !is_store && (ir_q[6:0] != OPC_BRANCH);

    // Outputs are registered alongside the state transition so they always
    // reflect the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            to_cnt_q  <= '0;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            ifu_req_q <= 1'b0;
            rf_wen_q  <= 1'b0;
            lsu_req_q <= 1'b0;
            lsu_we_q  <= 1'b0;
            halt_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_q   <= StFetch;
                    ifu_req_q <= 1'b1;
                end
                StFetch: begin
                    if (bus.ifu_valid) begin
                        ir_q      <= bus.ifu_inst;
                        ifu_req_q <= 1'b0;
                        state_q   <= StExec;
                    end
                end
                StExec: begin
                    if (is_ebreak) begin
                        state_q <= StHalt;
                        halt_q  <= 1'b1;
                        err_q   <= 1'b0;
                    end else if (is_load || is_store) begin
                        state_q   <= StMem;
                        lsu_req_q <= 1'b1;
                        lsu_we_q  <= is_store;
                    end else begin
                        state_q  <= StWb;
                        rf_wen_q <= wb_wen;
                    end
                end
                StMem: begin
                    // lsu_done takes priority over the timeout on the same cycle
                    if (bus.lsu_done) begin
                        lsu_req_q <= 1'b0;
                        lsu_we_q  <= 1'b0;
                        to_cnt_q  <= '0;
                        if (is_store) begin
                            pc_q      <= bus.dnpc;
                            ifu_req_q <= 1'b1;
                            state_q   <= StFetch;
                        end else begin
                            rf_wen_q <= wb_wen;
                            state_q  <= StWb;
                        end
                    end else if (to_cnt_q == MEM_TIMEOUT) begin
                        lsu_req_q <= 1'b0;
                        lsu_we_q  <= 1'b0;
                        to_cnt_q  <= '0;
                        halt_q    <= 1'b1;
                        err_q     <= 1'b1;
                        state_q   <= StHalt;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                StWb: begin
                    rf_wen_q  <= 1'b0;
                    pc_q      <= bus.dnpc;
                    ifu_req_q <= 1'b1;
                    state_q   <= StFetch;
                end
                StHalt: begin
                    // absorbing; only rst_n leaves
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.ifu_req = ifu_req_q;
    assign bus.ir      = ir_q;
    assign bus.pc      = pc_q;
    assign bus.rf_wen  = rf_wen_q;
    assign bus.lsu_req = lsu_req_q;
    assign bus.lsu_we  = lsu_we_q;
    assign bus.halt    = halt_q;
    assign bus.err     = err_q;

`ifdef EXU_SEQ_PERF_CNT_EN
    logic [63:0] cycle_cnt_q;
    logic [63:0] instret_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            if (state_q != StIdle && state_q != StHalt) begin
                cycle_cnt_q <= cycle_cnt_q + 64'd1;
            end
            // retire on WB or on store completion, including rd==x0
            if (state_q == StWb || (state_q == StMem && bus.lsu_done && is_store)) begin
                instret_cnt_q <= instret_cnt_q + 64'd1;
            end
        end
    end

    assign bus.cycle_cnt   = cycle_cnt_q;
    assign bus.instret_cnt = instret_cnt_q;
`endif

endmodule
